ervp_tick_alarm_scheduler: RTL
==============================

# ervp_tick_alarm_scheduler

Multi-channel alarm scheduler driven by the peripheral tick generator's `tick_1us` and `tick_62d5ms` pulses. It holds `NUM_CH` software-programmable countdown alarms (one-shot or periodic), each counting in one of the two tick units. A single shared decrementer services the channels in a round-robin scan, one channel per cycle. It sits in the common peripheral group between the tick generator and the interrupt aggregator.

## Interface
- `NUM_CH`, 4, number of alarm channels (2..16)
- `BW_PERIOD`, 16, width of period/remaining counters
- `BW_CH`, `REQUIRED_BITWIDTH_UNSIGNED(NUM_CH-1)`, channel index width
- `clk`  in  1  sole clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `tick_1us`  in  1  one-cycle microsecond tick
- `tick_62d5ms`  in  1  one-cycle 62.5 ms tick
- `cfg_wr`  in  1  config write strobe
- `cfg_ch`  in  BW_CH  channel written
- `cfg_enable`  in  1  channel enable
- `cfg_periodic`  in  1  1 = reload on expiry, 0 = one-shot
- `cfg_unit`  in  1  0 = us ticks, 1 = 62.5 ms ticks
- `cfg_period`  in  BW_PERIOD  period in ticks
- `alarm_clear`  in  NUM_CH  clears `alarm_pending` bits
- `alarm_pulse`  out  NUM_CH  one-cycle expiry pulse per channel
- `alarm_pending`  out  NUM_CH  sticky expiry flags
- `irq`  out  1  OR of `alarm_pending`
- `busy`  out  1  scanner in SCAN
- `tick_miss`  out  1  one-cycle pulse: tick lost

## Operation
- Per-channel state: `en`, `periodic`, `unit`, `period`, `remaining`.
- Config write: `remaining`←`cfg_period`; other fields from `cfg_*`. If `cfg_period==0`, `en` is forced to 0.
- Scanner FSM, two states:
  - IDLE: if a tick input or a pending flag is set, latch the pass flags `pass_us`/`pass_ms` = input|pending, clear pending, idx←0, go to SCAN.
  - SCAN: process channel idx. At idx==NUM_CH-1, go to SCAN again (new pass, flags relatched) if any tick input or pending is set, else go to IDLE.
- Processing channel i (`en` and pass flag of its `unit` set):
  - `remaining==1`: fire. Assert `alarm_pulse[i]` and set `alarm_pending[i]`. Periodic: `remaining`←`period`. One-shot: `en`←0.
  - Otherwise `remaining`←`remaining-1`.
  - Disabled channels and unmatched units are untouched.
- Ticks arriving during SCAN (other than at relatch) set pending for their unit. If that unit's pending is already set, `tick_miss` pulses and the tick is dropped. Remaining counts never go below 1.
- Simultaneous events:
  - `cfg_wr` to the channel being processed in that cycle: the write wins and the scanner result for that channel is discarded (no fire).
  - `alarm_clear[i]` together with a fire on i: the set wins.
  - Both tick inputs in the same cycle: both pass flags are set in one pass.
- A reset mid-scan aborts the pass. All channels are disabled and all pending state is lost.

## Timing
- Reset values: all outputs 0; FSM IDLE; all channel fields 0; pending flags 0.
- A tick sampled in IDLE at cycle t: channel i is processed at t+1+i, and `alarm_pulse[i]`/`alarm_pending[i]` are visible at t+2+i.
- `irq` is registered with `alarm_pending` (same cycle).
- `busy` = 1 exactly during SCAN cycles. Back-to-back passes keep `busy` high.
- Sustained throughput requires the tick interval to be at least NUM_CH cycles; a shorter interval produces `tick_miss`.
- `tick_miss` is asserted the cycle after the dropped tick.
- A config write takes effect the next cycle. A channel reconfigured mid-pass, before its slot, is processed in that same pass with the new values.

## Structure
- Shared package `ervp_tick_alarm_pkg`:
  - FSM state encoding (IDLE, SCAN).
  - Channel record typedef (`en`, `periodic`, `unit`, `period`, `remaining`).
  - Unit constants UNIT_US=0, UNIT_62D5MS=1.
- Sub-module `ervp_tick_alarm_chreg`: the channel register array with its write port (config) and read-modify-write port (scanner), including the write-wins collision rule.
- The top level holds the FSM, pending/miss logic, shared decrementer and status flags.

## Test plan
- One-shot basic: ch0, period 3, us unit; 3 `tick_1us` pulses 10 cycles apart -> `alarm_pulse[0]` once, 2 cycles after the 3rd tick; `en` clears; a 4th tick produces no pulse.
- Periodic, mixed units: ch1 period 2 us periodic, ch2 period 1 ms-unit; 6 us ticks plus 1 ms tick -> ch1 fires 3 times, ch2 once; `alarm_pending`=0b0110; `alarm_clear`=0b0010 -> 0b0100.
- Tick miss: NUM_CH=4; us ticks at cycles 0, 1, 2 -> third tick raises `tick_miss` at cycle 3; exactly two passes execute back-to-back and `busy` stays high 8 cycles.
- Collision: `cfg_wr` ch1 period 5 in the cycle ch1 is processed with `remaining`=1 -> no fire; `remaining` reads 5.
- Clear vs. set: `alarm_clear[0]` asserted in ch0's fire-visible cycle -> `alarm_pending[0]` stays 1.
- Reset mid-scan: `rst` at idx 2 -> all outputs 0 next cycle; subsequent ticks produce no pulses until reconfigured.

Source files
------------

// File: rtl/ervp_tick_alarm_pkg.sv
// Shared types for the tick alarm scheduler: scanner states, channel record,
// and tick unit selectors.
package ervp_tick_alarm_pkg;

    // Storage width of a channel's period/remaining fields (the top's BW_PERIOD must not exceed it)
    localparam int unsigned CH_PERIOD_W = 16;

    localparam logic UNIT_US     = 1'b0;
    localparam logic UNIT_62D5MS = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic                   en;
        logic                   periodic;
        logic                   unit;
        logic [CH_PERIOD_W-1:0] period;
        logic [CH_PERIOD_W-1:0] remaining;
    } ch_rec_t;

endpackage

// File: rtl/ervp_tick_alarm_chreg.sv
// Channel register array.
// Ports: clk/rst (sync, active-high); wr_* config write port; rmw_* scanner
// write-back port; rd_ch/rd_rec_c combinational read for the scanner.
// A config write and a scanner write-back to the same channel in one cycle
// resolve in favour of the config write.
module ervp_tick_alarm_chreg
    import ervp_tick_alarm_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned BW_CH  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [BW_CH-1:0] wr_ch,
    input  ch_rec_t          wr_rec,
    input  logic             rmw_en,
    input  logic [BW_CH-1:0] rmw_ch,
    input  ch_rec_t          rmw_rec,
    input  logic [BW_CH-1:0] rd_ch,
    output ch_rec_t          rd_rec_c
);

    ch_rec_t regs [NUM_CH];

    assign rd_rec_c = regs[rd_ch];

    // Config write is ordered last so it overrides the scanner on a collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (rmw_en) begin
                regs[rmw_ch] <= rmw_rec;
            end
            if (wr_en) begin
                regs[wr_ch] <= wr_rec;
            end
        end
    end

endmodule

// File: rtl/ervp_tick_alarm_scheduler.sv
// Multi-channel tick alarm scheduler with a round-robin shared decrementer.
// Ports: clk, rst (sync, active-high); tick_1us/tick_62d5ms tick inputs;
// cfg_* channel configuration write; alarm_clear sticky-flag clear;
// alarm_pulse/alarm_pending/irq alarm status; busy (scan in progress);
// tick_miss (a tick was dropped).
module ervp_tick_alarm_scheduler
    import ervp_tick_alarm_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned BW_PERIOD = 16,
    parameter int unsigned BW_CH     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_1us,
    input  logic                 tick_62d5ms,
    input  logic                 cfg_wr,
    input  logic [BW_CH-1:0]     cfg_ch,
    input  logic                 cfg_enable,
    input  logic                 cfg_periodic,
    input  logic                 cfg_unit,
    input  logic [BW_PERIOD-1:0] cfg_period,
    input  logic [NUM_CH-1:0]    alarm_clear,
    output logic [NUM_CH-1:0]    alarm_pulse,
    output logic [NUM_CH-1:0]    alarm_pending,
    output logic                 irq,
    output logic                 busy,
    output logic                 tick_miss
);

    localparam logic [BW_CH-1:0] LAST_IDX = BW_CH'(NUM_CH - 1);

    scan_state_e       state_q, state_d;
    logic [BW_CH-1:0]  idx_q, idx_d;
    logic              pass_us_q, pass_us_d, pass_ms_q, pass_ms_d;
    logic              pend_us_q, pend_us_d, pend_ms_q, pend_ms_d;
    logic [NUM_CH-1:0] pulse_d, pending_d;
    logic              miss_d;

    ch_rec_t           rec, rec_upd, wr_rec;
    logic              rmw_en, fire, unit_hit, collide, any_evt;
    logic [NUM_CH-1:0] ch_bit;

    // A zero period can never expire, so such a channel is stored disabled
    always_comb begin
        wr_rec.en        = cfg_enable && (cfg_period != '0);
        wr_rec.periodic  = cfg_periodic;
        wr_rec.unit      = cfg_unit;
        wr_rec.period    = CH_PERIOD_W'(cfg_period);
        wr_rec.remaining = CH_PERIOD_W'(cfg_period);
    end

    ervp_tick_alarm_chreg #(
        .NUM_CH (NUM_CH),
        .BW_CH  (BW_CH)
    ) u_chreg (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cfg_wr),
        .wr_ch    (cfg_ch),
        .wr_rec   (wr_rec),
        .rmw_en   (rmw_en),
        .rmw_ch   (idx_q),
        .rmw_rec  (rec_upd),
        .rd_ch    (idx_q),
        .rd_rec_c (rec)
    );

    assign ch_bit   = NUM_CH'(1) << idx_q;
    assign collide  = cfg_wr && (cfg_ch == idx_q);
    assign any_evt  = tick_1us || tick_62d5ms || pend_us_q || pend_ms_q;
    assign unit_hit = ((rec.unit == UNIT_US) && pass_us_q) ||
                      ((rec.unit == UNIT_62D5MS) && pass_ms_q);

    // Shared decrementer, scanner FSM and pending/miss bookkeeping
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pass_us_d = pass_us_q;
        pass_ms_d = pass_ms_q;
        pend_us_d = pend_us_q;
        pend_ms_d = pend_ms_q;
        miss_d    = 1'b0;
        pulse_d   = '0;
        pending_d = alarm_pending & ~alarm_clear;
        rec_upd   = rec;
        rmw_en    = 1'b0;
        fire      = 1'b0;

        if ((state_q == ST_SCAN) && rec.en && unit_hit) begin
            rmw_en = 1'b1;
            if (rec.remaining <= CH_PERIOD_W'(1)) begin
                fire = !collide;
                if (rec.periodic) begin
                    rec_upd.remaining = rec.period;
                end else begin
                    rec_upd.en = 1'b0;
                end
            end else begin
                rec_upd.remaining = rec.remaining - CH_PERIOD_W'(1);
            end
        end

        // Set beats a simultaneous clear
        if (fire) begin
            pulse_d   = ch_bit;
            pending_d = pending_d | ch_bit;
        end

        case (state_q)
            ST_IDLE: begin
                if (any_evt) begin
                    pass_us_d = tick_1us || pend_us_q;
                    pass_ms_d = tick_62d5ms || pend_ms_q;
                    pend_us_d = 1'b0;
                    pend_ms_d = 1'b0;
                    idx_d     = '0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (idx_q == LAST_IDX) begin
                    // Pass boundary: ticks here feed the next pass directly
                    if (any_evt) begin
                        pass_us_d = tick_1us || pend_us_q;
                        pass_ms_d = tick_62d5ms || pend_ms_q;
                        pend_us_d = 1'b0;
                        pend_ms_d = 1'b0;
                        idx_d     = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + BW_CH'(1);
                    if (tick_1us) begin
                        if (pend_us_q) miss_d = 1'b1;
                        else           pend_us_d = 1'b1;
                    end
                    if (tick_62d5ms) begin
                        if (pend_ms_q) miss_d = 1'b1;
                        else           pend_ms_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            pass_us_q     <= 1'b0;
            pass_ms_q     <= 1'b0;
            pend_us_q     <= 1'b0;
            pend_ms_q     <= 1'b0;
            alarm_pulse   <= '0;
            alarm_pending <= '0;
            irq           <= 1'b0;
            busy          <= 1'b0;
            tick_miss     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pass_us_q     <= pass_us_d;
            pass_ms_q     <= pass_ms_d;
            pend_us_q     <= pend_us_d;
            pend_ms_q     <= pend_ms_d;
            alarm_pulse   <= pulse_d;
            alarm_pending <= pending_d;
            irq           <= |pending_d;
            busy          <= (state_d == ST_SCAN);
            tick_miss     <= miss_d;
        end
    end

endmodule
